// File: rtl/d_reg_pkg.sv
// Shared types for the d_reg storage bank.
package d_reg_pkg;

  // Per-edge operation applied to every gated-on channel.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_SHR  = 2'b11
  } mode_e;

endpackage

// File: rtl/d_reg_chan.sv
// Single storage channel: WIDTH-bit register with hold/load/shift modes,
// clock enable, sticky change flag and complemented output.
module d_reg_chan
  import d_reg_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               ROTATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             g,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             chg
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             chg_q, chg_d;
  logic             shl_bit, shr_bit;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  // Rotate mode recirculates the bit falling off the opposite end instead of si.
  assign shl_bit = ROTATE ? q_q[WIDTH-1] : si;
  assign shr_bit = ROTATE ? q_q[0]       : si;

  // Next value of the register; gate low forces hold.
  always_comb begin
    q_d = q_q;
    if (g) begin
      unique case (mode_sel)
        MODE_HOLD: q_d = q_q;
        MODE_LOAD: q_d = d;
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], shl_bit};
        MODE_SHR:  q_d = {shr_bit, q_q[WIDTH-1:1]};
        default:   q_d = q_q;
      endcase
    end
  end

  // Change flag: a real value change on this edge beats a simultaneous clear.
  always_comb begin
    chg_d = (chg_q & ~clr) | (q_d != q_q);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= RST_VAL;
      chg_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
    end
  end

  assign q   = q_q;
  assign qn  = ~q_q;
  assign chg = chg_q;

endmodule

// File: rtl/d_reg_bank.sv
// Multi-channel storage bank: NUM_CH independent d_reg_chan instances
// sharing clock, reset and mode, with packed data buses.
module d_reg_bank
  import d_reg_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      NUM_CH  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               ROTATE  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       g,
  input  logic [1:0]              mode,
  input  logic [NUM_CH*WIDTH-1:0] d,
  input  logic [NUM_CH-1:0]       si,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH*WIDTH-1:0] q,
  output logic [NUM_CH*WIDTH-1:0] qn,
  output logic [NUM_CH-1:0]       chg
);

  for (genvar c = 0; c < NUM_CH; c++) begin : gen_chan
    d_reg_chan #(
      .WIDTH  (WIDTH),
      .RST_VAL(RST_VAL),
      .ROTATE (ROTATE)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .g    (g[c]),
      .mode (mode),
      .d    (d[c*WIDTH +: WIDTH]),
      .si   (si[c]),
      .clr  (clr[c]),
      .q    (q[c*WIDTH +: WIDTH]),
      .qn   (qn[c*WIDTH +: WIDTH]),
      .chg  (chg[c])
    );
  end

endmodule

// File: tb/tb_d_reg_bank.sv
// Directed and randomised checks of d_reg_bank in three configurations:
// a: shift-in, reset 00; b: rotate, reset 00; c: shift-in, reset 5A.
module tb_d_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  g = '0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] d = '0;
  logic [1:0]  si = '0;
  logic [1:0]  clr = '0;
  logic [15:0] q_a, qn_a, q_b, qn_b, q_c, qn_c;
  logic [1:0]  chg_a, chg_b, chg_c;

  int vectors = 0;
  int errors  = 0;

  localparam logic [1:0] HOLD = 2'b00, LOAD = 2'b01, SHL = 2'b10, SHR = 2'b11;

  always #5 clk = ~clk;

  d_reg_bank #(.WIDTH(8), .NUM_CH(2), .RST_VAL(8'h00), .ROTATE(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .g(g), .mode(mode), .d(d), .si(si), .clr(clr),
    .q(q_a), .qn(qn_a), .chg(chg_a)
  );
  d_reg_bank #(.WIDTH(8), .NUM_CH(2), .RST_VAL(8'h00), .ROTATE(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .g(g), .mode(mode), .d(d), .si(si), .clr(clr),
    .q(q_b), .qn(qn_b), .chg(chg_b)
  );
  d_reg_bank #(.WIDTH(8), .NUM_CH(2), .RST_VAL(8'h5A), .ROTATE(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .g(g), .mode(mode), .d(d), .si(si), .clr(clr),
    .q(q_c), .qn(qn_c), .chg(chg_c)
  );

  // Apply one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    g = 2'b00; mode = HOLD;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (q_a !== 16'h0000 || qn_a !== 16'hFFFF || chg_a !== 2'b00) begin
      errors++;
      $display("FAIL reset_a: q=%h qn=%h chg=%b, want 0000 ffff 00", q_a, qn_a, chg_a);
    end
    vectors++;
    if (q_c !== 16'h5A5A || qn_c !== 16'hA5A5 || chg_c !== 2'b00) begin
      errors++;
      $display("FAIL reset_c: q=%h qn=%h chg=%b, want 5a5a a5a5 00", q_c, qn_c, chg_c);
    end
    // Edges while held in reset must not load.
    mode = LOAD; g = 2'b11; d = 16'hFFFF;
    step();
    vectors++;
    if (q_a !== 16'h0000) begin
      errors++;
      $display("FAIL reset_held: q=%h, want 0000", q_a);
    end
    g = 2'b00;
    #1 rst_n = 1'b1;
    step(); step();
    vectors++;
    if (q_a !== 16'h0000 || chg_a !== 2'b00) begin
      errors++;
      $display("FAIL gate_off_hold: q=%h chg=%b, want 0000 00", q_a, chg_a);
    end
  endtask

  task automatic test_load_gate();
    g = 2'b01; mode = LOAD; d = {8'hA5, 8'h3C};
    step();
    vectors++;
    if (q_a !== 16'h003C || chg_a !== 2'b01 || qn_a !== 16'hFFC3) begin
      errors++;
      $display("FAIL load_gated: q=%h qn=%h chg=%b, want 003c ffc3 01", q_a, qn_a, chg_a);
    end
    step();
    vectors++;
    if (q_a !== 16'h003C || chg_a !== 2'b01) begin
      errors++;
      $display("FAIL load_same: q=%h chg=%b, want 003c 01", q_a, chg_a);
    end
    mode = HOLD; clr = 2'b01;
    step();
    clr = 2'b00;
    vectors++;
    if (q_a !== 16'h003C || chg_a !== 2'b00) begin
      errors++;
      $display("FAIL clr: q=%h chg=%b, want 003c 00", q_a, chg_a);
    end
  endtask

  task automatic test_shift();
    g = 2'b01; mode = SHL; si = 2'b01;
    step(); step(); step();
    vectors++;
    if (q_a[7:0] !== 8'hE7 || chg_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL shl_si: q0=%h chg0=%b, want e7 1", q_a[7:0], chg_a[0]);
    end
    mode = SHR; si = 2'b00;
    step();
    vectors++;
    if (q_a[7:0] !== 8'h73 || q_a[15:8] !== 8'h00) begin
      errors++;
      $display("FAIL shr_si: q=%h, want 0073", q_a);
    end
  endtask

  task automatic test_rotate();
    g = 2'b10; mode = LOAD; d = {8'h81, 8'h00};
    step();
    mode = SHL; si = 2'b00;
    step();
    vectors++;
    if (q_b[15:8] !== 8'h03) begin
      errors++;
      $display("FAIL rot_shl: q1=%h, want 03", q_b[15:8]);
    end
    mode = SHR; si = 2'b10;
    step();
    si = 2'b00;
    step();
    vectors++;
    if (q_b[15:8] !== 8'hC0) begin
      errors++;
      $display("FAIL rot_shr: q1=%h, want c0", q_b[15:8]);
    end
  endtask

  task automatic test_clr_priority();
    g = 2'b01; mode = HOLD; clr = 2'b01;
    step();
    vectors++;
    if (chg_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL pre_clr: chg0=%b, want 0", chg_a[0]);
    end
    mode = LOAD; d = 16'h0055;
    step();
    vectors++;
    if (q_a[7:0] !== 8'h55 || chg_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: q0=%h chg0=%b, want 55 1", q_a[7:0], chg_a[0]);
    end
    mode = HOLD;
    step();
    clr = 2'b00;
    vectors++;
    if (q_a[7:0] !== 8'h55 || chg_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL clr_after: q0=%h chg0=%b, want 55 0", q_a[7:0], chg_a[0]);
    end
  endtask

  function automatic logic [7:0] next_val(logic [7:0] cur, logic [1:0] m, logic gg,
                                          logic [7:0] dd, logic s, bit rot);
    logic b;
    if (!gg) return cur;
    case (m)
      LOAD: return dd;
      SHL: begin
        b = rot ? cur[7] : s;
        return (cur << 1) | {7'b0, b};
      end
      SHR: begin
        b = rot ? cur[0] : s;
        return (cur >> 1) | {b, 7'b0};
      end
      default: return cur;
    endcase
  endfunction

  task automatic test_random();
    logic [7:0]  mq [3][2];
    logic        mc [3][2];
    logic [7:0]  rv [3];
    bit          rot [3];
    logic [15:0] oq, oqn;
    logic [1:0]  oc;
    logic [7:0]  nv;
    rv[0] = 8'h00; rv[1] = 8'h00; rv[2] = 8'h5A;
    rot[0] = 1'b0; rot[1] = 1'b1; rot[2] = 1'b0;
    // Start from a known state.
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) for (int c = 0; c < 2; c++) begin
      mq[k][c] = rv[k]; mc[k][c] = 1'b0;
    end
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        vectors++;
        if (q_a !== 16'h0000 || q_b !== 16'h0000 || q_c !== 16'h5A5A ||
            qn_c !== 16'hA5A5 || chg_a !== 2'b00 || chg_c !== 2'b00) begin
          errors++;
          $display("FAIL rand_reset %0d: a=%h b=%h c=%h qn_c=%h", n, q_a, q_b, q_c, qn_c);
        end
        for (int k = 0; k < 3; k++) for (int c = 0; c < 2; c++) begin
          mq[k][c] = rv[k]; mc[k][c] = 1'b0;
        end
        #1 rst_n = 1'b1;
      end
      g = 2'($urandom); mode = 2'($urandom); d = 16'($urandom);
      si = 2'($urandom); clr = 2'($urandom);
      for (int k = 0; k < 3; k++) for (int c = 0; c < 2; c++) begin
        nv = next_val(mq[k][c], mode, g[c], d[c*8 +: 8], si[c], rot[k]);
        mc[k][c] = (mc[k][c] && !clr[c]) || (nv != mq[k][c]);
        mq[k][c] = nv;
      end
      step();
      for (int k = 0; k < 3; k++) begin
        case (k)
          0: begin oq = q_a; oqn = qn_a; oc = chg_a; end
          1: begin oq = q_b; oqn = qn_b; oc = chg_b; end
          default: begin oq = q_c; oqn = qn_c; oc = chg_c; end
        endcase
        vectors++;
        if (oq !== {mq[k][1], mq[k][0]} || oqn !== ~{mq[k][1], mq[k][0]} ||
            oc !== {mc[k][1], mc[k][0]}) begin
          errors++;
          $display("FAIL rand %0d dut%0d: q=%h qn=%h chg=%b, want q=%h chg=%b", n, k,
                   oq, oqn, oc, {mq[k][1], mq[k][0]}, {mc[k][1], mc[k][0]});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_gate();
    test_shift();
    test_rotate();
    test_clr_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
